// File: rtl/slow_en_pkg.sv
// Shared types and defaults for the slowena pulse generator.
package slow_en_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIV   = 9;
endpackage

// File: rtl/reload_downcounter.sv
// Loadable down-counter with synchronous clear; saturates at zero so it never wraps.
module reload_downcounter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt,
    output logic             zero
);
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/slow_enable_gen.sv
// Programmable slowena pulse generator with free-run, pause and single-step modes.
module slow_enable_gen
    import slow_en_pkg::*;
#(
    parameter int          WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    input  logic             run,
    input  logic             step,
    output logic             slowena,
    output logic             busy,
    output logic [WIDTH-1:0] phase
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] div_reg;
    logic             cnt_load, cnt_dec, cnt_clear, cnt_zero;
    logic             slowena_nxt;

    // A load on the same edge as a reload lets the reload see the old divider.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            div_reg <= WIDTH'(DEFAULT_DIV);
        end else if (div_load) begin
            div_reg <= div_value;
        end
    end

    reload_downcounter #(.WIDTH(WIDTH)) u_cnt (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (cnt_load),
        .load_val (div_reg),
        .dec      (cnt_dec),
        .clear    (cnt_clear),
        .cnt      (phase),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            slowena <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            slowena <= slowena_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_clear   = 1'b0;
        slowena_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = RUN;
                    cnt_load  = 1'b1;
                end else if (step) begin
                    state_nxt = STEP;
                    cnt_load  = 1'b1;
                end
            end
            RUN: begin
                // Leaving RUN wins over a pulse due on the same edge.
                if (!run) begin
                    state_nxt = IDLE;
                    cnt_clear = 1'b1;
                end else if (cnt_zero) begin
                    slowena_nxt = 1'b1;
                    cnt_load    = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            STEP: begin
                if (cnt_zero) begin
                    slowena_nxt = 1'b1;
                    if (run) begin
                        state_nxt = RUN;
                        cnt_load  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        cnt_clear = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end
endmodule
